// File: rtl/crossbar_route_scheduler.sv
// Route scheduler for the 4x4 five-switch crossbar: given the desired output
// index for each of the four inputs, scans control words 0..31 in ascending
// order and reports the lowest one that realises the routing, or an error code.
module crossbar_route_scheduler #(
    parameter bit PRE_CHECK = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] dst1,
    input  logic [1:0] dst2,
    input  logic [1:0] dst3,
    input  logic [1:0] dst4,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [1:0] rsp_code,
    output logic [4:0] ctl_out
);

    typedef enum logic [1:0] {IDLE, SEARCH, RESP} state_t;

    localparam logic [1:0] CODE_OK    = 2'b00;
    localparam logic [1:0] CODE_UNRCH = 2'b01;
    localparam logic [1:0] CODE_NPERM = 2'b10;

    state_t     state_q;
    logic [1:0] dst1_q, dst2_q, dst3_q, dst4_q;
    logic [4:0] cnt_q;
    logic [4:0] cand_q;
    logic       hit_q;
    logic       pend_q;
    logic       req_ready_q;
    logic       rsp_valid_q;
    logic [1:0] code_q;
    logic [4:0] ctl_q;

    logic       cand_ok;
    logic       dup;

    // Input label (0..3 = in1..in4) that lands on output position idx.
    function automatic logic [1:0] pick(input logic [1:0] o0, input logic [1:0] o1,
                                        input logic [1:0] o2, input logic [1:0] o3,
                                        input logic [1:0] idx);
        logic [1:0] r;
        case (idx)
            2'd0:    r = o0;
            2'd1:    r = o1;
            2'd2:    r = o2;
            default: r = o3;
        endcase
        return r;
    endfunction

    // Push input labels through the five switches and check every input
    // arrives at its requested output.
    function automatic logic route_ok(input logic [4:0] ctl,
                                      input logic [1:0] d1, input logic [1:0] d2,
                                      input logic [1:0] d3, input logic [1:0] d4);
        logic [1:0] a0, a1, b0, b1, c0, c1, o0, o1, o2, o3;
        a0 = ctl[0] ? 2'd1 : 2'd0;
        a1 = ctl[0] ? 2'd0 : 2'd1;
        b0 = ctl[1] ? 2'd3 : 2'd2;
        b1 = ctl[1] ? 2'd2 : 2'd3;
        c0 = ctl[2] ? b0 : a1;
        c1 = ctl[2] ? a1 : b0;
        o0 = ctl[3] ? c0 : a0;
        o1 = ctl[3] ? a0 : c0;
        o2 = ctl[4] ? b1 : c1;
        o3 = ctl[4] ? c1 : b1;
        return (pick(o0, o1, o2, o3, d1) == 2'd0) && (pick(o0, o1, o2, o3, d2) == 2'd1) &&
               (pick(o0, o1, o2, o3, d3) == 2'd2) && (pick(o0, o1, o2, o3, d4) == 2'd3);
    endfunction

    assign cand_ok = route_ok(cnt_q, dst1_q, dst2_q, dst3_q, dst4_q);
    assign dup     = (dst1_q == dst2_q) || (dst1_q == dst3_q) || (dst1_q == dst4_q) ||
                     (dst2_q == dst3_q) || (dst2_q == dst4_q) || (dst3_q == dst4_q);

    // Request/search/response FSM; candidate results are registered one cycle
    // (hit_q/cand_q) before the decision, and pend_q marks a result is waiting.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            code_q      <= CODE_OK;
            ctl_q       <= 5'd0;
            cnt_q       <= 5'd0;
            pend_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid && req_ready_q) begin
                        dst1_q      <= dst1;
                        dst2_q      <= dst2;
                        dst3_q      <= dst3;
                        dst4_q      <= dst4;
                        cnt_q       <= 5'd0;
                        pend_q      <= 1'b0;
                        req_ready_q <= 1'b0;
                        state_q     <= SEARCH;
                    end
                end
                SEARCH: begin
                    if (!pend_q && PRE_CHECK && dup) begin
                        // Duplicate destinations can never form a permutation.
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        code_q      <= CODE_NPERM;
                        ctl_q       <= 5'd0;
                    end else if (pend_q && hit_q) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        code_q      <= CODE_OK;
                        ctl_q       <= cand_q;
                    end else if (pend_q && (cand_q == 5'd31)) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        code_q      <= CODE_UNRCH;
                        ctl_q       <= 5'd0;
                    end else begin
                        hit_q  <= cand_ok;
                        cand_q <= cnt_q;
                        pend_q <= 1'b1;
                        if (cnt_q != 5'd31) begin
                            cnt_q <= cnt_q + 5'd1;
                        end
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_code  = code_q;
    assign ctl_out   = ctl_q;

endmodule
